// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential/stall/redirect/halt with multi-cycle flush.
// Optional perf counters when PC_SEQ_PERF_EN is defined.
module pc_sequencer #(
  parameter int              PC_W         = 36,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              PC_INC       = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            br_valid_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  output logic            br_ready_o,
  input  logic            exc_valid_i,
  input  logic [PC_W-1:0] exc_vector_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] fetch_pc_o,
  output logic            fetch_valid_o,
  output logic            flush_o,
  output logic            halted_o
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]     redirect_cnt_o,
  output logic [31:0]     flush_cyc_cnt_o
`endif
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] FLUSH  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [PC_W-1:0] INC  = PC_W'(PC_INC);
  localparam logic [2:0]      LOAD = 3'(FLUSH_CYCLES);

  logic [1:0]      state;
  logic [2:0]      cnt;
  logic            take_br;
  logic            accept;
  logic [PC_W-1:0] target;

  // Exceptions are honoured in every state; branches only while in RUN.
  assign take_br = br_valid_i & br_taken_i & br_ready_o;
  assign accept  = exc_valid_i | take_br;
  assign target  = exc_valid_i ? exc_vector_i : br_target_i;

  assign br_ready_o    = (state == RUN);
  assign fetch_valid_o = (state == RUN) & ~rst;
  assign flush_o       = (state == FLUSH);
  assign halted_o      = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      fetch_pc_o <= RESET_PC;
      cnt        <= '0;
    end else if (accept) begin
      state      <= FLUSH;
      fetch_pc_o <= target;
      cnt        <= LOAD;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_i)
            state <= HALTED;
          else if (!stall_i)
            fetch_pc_o <= fetch_pc_o + INC;
        end
        FLUSH: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1)
            state <= RUN;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_o  <= '0;
      flush_cyc_cnt_o <= '0;
    end else begin
      if (accept && redirect_cnt_o != '1)
        redirect_cnt_o <= redirect_cnt_o + 32'd1;
      if (flush_o && flush_cyc_cnt_o != '1)
        flush_cyc_cnt_o <= flush_cyc_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table, hand sequences, random vs model.
// Perf counters are checked when PC_SEQ_PERF_EN is defined.
module tb_pc_sequencer;

  localparam int F = 2;
  localparam logic [35:0] ONES = 36'hF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [35:0] br_target;
  logic        br_ready;
  logic        exc_valid;
  logic [35:0] exc_vector;
  logic        halt;
  logic [35:0] fetch_pc;
  logic        fetch_valid;
  logic        flush;
  logic        halted;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] redirect_cnt;
  logic [31:0] flush_cyc_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W(36), .RESET_PC(36'h0), .FLUSH_CYCLES(F), .PC_INC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall),
    .br_valid_i(br_valid),
    .br_taken_i(br_taken),
    .br_target_i(br_target),
    .br_ready_o(br_ready),
    .exc_valid_i(exc_valid),
    .exc_vector_i(exc_vector),
    .halt_i(halt),
    .fetch_pc_o(fetch_pc),
    .fetch_valid_o(fetch_valid),
    .flush_o(flush),
    .halted_o(halted)
`ifdef PC_SEQ_PERF_EN
    ,
    .redirect_cnt_o(redirect_cnt),
    .flush_cyc_cnt_o(flush_cyc_cnt)
`endif
  );

  typedef struct {
    bit          rst, stall, bv, bt;
    logic [35:0] tgt;
    bit          ev;
    logic [35:0] vec;
    bit          halt;
    logic [35:0] pc;
    bit          v, f, h, r;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic add(input bit r_, s_, bv_, bt_, input logic [35:0] t_,
                     input bit ev_, input logic [35:0] vc_, input bit h_,
                     input logic [35:0] pc_, input bit v_, f_, hd_, rd_);
    tab.push_back('{r_, s_, bv_, bt_, t_, ev_, vc_, h_,
                    pc_, v_, f_, hd_, rd_});
  endtask

  task automatic drive(input bit r_, s_, bv_, bt_, input logic [35:0] t_,
                       input bit ev_, input logic [35:0] vc_, input bit h_);
    rst = r_; stall = s_; br_valid = bv_; br_taken = bt_;
    br_target = t_; exc_valid = ev_; exc_vector = vc_; halt = h_;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  // Reference model state
  logic [35:0] mpc;
  int          mfl;
  bit          mhalt;
  longint      mred, mflc;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;

    //  rst st bv bt tgt         ev vec       hlt | pc         v f h r
    add(1, 0, 0, 0, 0,          0, 0,        0,   36'h0,     0,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h0,     1,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h1,     1,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h2,     1,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h3,     1,0,0,1);
    add(0, 0, 1, 1, 36'h10,     0, 0,        0,   36'h4,     1,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h10,    0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h10,    0,1,0,0);
    add(0, 1, 0, 0, 0,          0, 0,        0,   36'h10,    1,0,0,1);
    add(0, 1, 0, 0, 0,          0, 0,        0,   36'h10,    1,0,0,1);
    add(0, 1, 0, 0, 0,          0, 0,        0,   36'h10,    1,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h10,    1,0,0,1);
    add(0, 0, 1, 1, 36'h20,     0, 0,        0,   36'h11,    1,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h20,    0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h20,    0,1,0,0);
    add(0, 0, 1, 1, 36'h400,    0, 0,        1,   36'h20,    1,0,0,1);
    add(0, 0, 1, 1, 36'h500,    0, 0,        1,   36'h400,   0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h400,   0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h400,   1,0,0,1);
    add(0, 0, 1, 0, 36'h999,    0, 0,        0,   36'h401,   1,0,0,1);
    add(0, 0, 1, 1, 36'h400,    1, 36'h8,    0,   36'h402,   1,0,0,1);
    add(0, 0, 1, 1, 36'h600,    0, 0,        0,   36'h8,     0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h8,     0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h8,     1,0,0,1);
    add(0, 0, 0, 0, 0,          1, 36'h30,   0,   36'h9,     1,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h30,    0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h30,    0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        1,   36'h30,    1,0,0,1);
    add(0, 1, 0, 0, 0,          0, 0,        1,   36'h30,    0,0,1,0);
    add(0, 0, 1, 1, 36'h700,    0, 0,        0,   36'h30,    0,0,1,0);
    add(0, 0, 0, 0, 0,          1, 36'h100,  0,   36'h30,    0,0,1,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h100,   0,1,0,0);
    add(0, 0, 0, 0, 0,          1, 36'h200,  0,   36'h100,   0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h200,   0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h200,   0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h200,   1,0,0,1);
    add(0, 0, 1, 1, 36'h800,    0, 0,        0,   36'h201,   1,0,0,1);
    add(1, 0, 0, 0, 0,          0, 0,        0,   36'h800,   0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h0,     1,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        1,   36'h1,     1,0,0,1);
    add(1, 0, 0, 0, 0,          0, 0,        0,   36'h1,     0,0,1,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h0,     1,0,0,1);
    add(0, 0, 1, 1, ONES,       0, 0,        0,   36'h1,     1,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        0,   ONES,      0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   ONES,      0,1,0,0);
    add(0, 0, 0, 0, 0,          0, 0,        0,   ONES,      1,0,0,1);
    add(0, 0, 0, 0, 0,          0, 0,        0,   36'h0,     1,0,0,1);

    foreach (tab[i]) begin
      drive(tab[i].rst, tab[i].stall, tab[i].bv, tab[i].bt, tab[i].tgt,
            tab[i].ev, tab[i].vec, tab[i].halt);
      @(negedge clk);
      chk($sformatf("row%0d_pc", i), 64'(fetch_pc), 64'(tab[i].pc));
      chk($sformatf("row%0d_valid", i), 64'(fetch_valid), 64'(tab[i].v));
      chk($sformatf("row%0d_flush", i), 64'(flush), 64'(tab[i].f));
      chk($sformatf("row%0d_halted", i), 64'(halted), 64'(tab[i].h));
      chk($sformatf("row%0d_ready", i), 64'(br_ready), 64'(tab[i].r));
      @(posedge clk); #1;
    end

    // Redirect latency: target visible next cycle, valid after F cycles
    begin
      int n;
      drive(0, 1, 1, 1, 36'h1234, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("lat_pc_next", 64'(fetch_pc), 64'h1234);
      chk("lat_flush_next", 64'(flush), 64'd1);
      n = 0;
      while (!fetch_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("lat_cycles", 64'(n), 64'(F));
      chk("lat_pc_valid", 64'(fetch_pc), 64'h1234);
    end

`ifdef PC_SEQ_PERF_EN
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("perf_rst_redir", 64'(redirect_cnt), 64'd0);
    chk("perf_rst_flush", 64'(flush_cyc_cnt), 64'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) drive(0, 0, 0, 0, 0, 1, 36'h40, 0);
      else drive(0, 0, 1, 1, 36'h80 + 36'(k), 0, 0, 0);
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) idle_cycle();
    end
    @(negedge clk);
    chk("perf_redir", 64'(redirect_cnt), 64'd3);
    chk("perf_flush", 64'(flush_cyc_cnt), 64'd6);
    @(posedge clk); #1;
`endif

    // Randomized run against the behavioural model
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    mpc = 36'h0; mfl = 0; mhalt = 0; mred = 0; mflc = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [35:0] t, v;
      bit ready, ev_v;
      t = {4'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) t = ONES - 36'($urandom_range(0, 3));
      v = {4'($urandom), 32'($urandom)};
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, t,
            $urandom_range(0, 15) == 0, v, $urandom_range(0, 15) == 0);
      @(negedge clk);
      ready = !mhalt && mfl == 0;
      chk($sformatf("rand%0d", c),
          64'({fetch_pc, fetch_valid, flush, halted, br_ready}),
          64'({mpc, ready && !rst, mfl > 0, mhalt, ready}));
`ifdef PC_SEQ_PERF_EN
      chk($sformatf("rand%0d_perf", c),
          {redirect_cnt, flush_cyc_cnt}, {32'(mred), 32'(mflc)});
`endif
      ev_v = exc_valid;
      if (rst) begin
        mpc = 36'h0; mfl = 0; mhalt = 0; mred = 0; mflc = 0;
      end else begin
        if (mfl > 0) mflc++;
        if (ev_v) begin
          mpc = exc_vector; mfl = F; mhalt = 0; mred++;
        end else if (ready && br_valid && br_taken) begin
          mpc = br_target; mfl = F; mred++;
        end else if (mfl > 0) begin
          mfl--;
        end else if (mhalt) begin
          mhalt = 1;
        end else if (halt) begin
          mhalt = 1;
        end else if (!stall) begin
          mpc = 36'((64'(mpc) + 64'd1) % 64'h10_0000_0000);
        end
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
